// File: rtl/hpm_sample_ctrl.sv
// hpm_sample_ctrl: perf-counter port arbiter with a counter sampling engine.
// Define HPM_SAMPLE_TIMESTAMP_EN to append a cycle-count timestamp beat.
module hpm_sample_ctrl #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned NumCnt  = 6,
    parameter int unsigned PeriodW = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               debug_mode_i,
    input  logic               csr_req_i,
    input  logic [11:0]        csr_addr_i,
    input  logic               csr_we_i,
    input  logic [XLEN-1:0]    csr_wdata_i,
    output logic [XLEN-1:0]    csr_rdata_o,
    output logic [11:0]        pc_addr_o,
    output logic               pc_we_o,
    output logic [XLEN-1:0]    pc_wdata_o,
    input  logic [XLEN-1:0]    pc_rdata_i,
    input  logic               sample_en_i,
    input  logic [PeriodW-1:0] sample_period_i,
    input  logic               trigger_i,
    output logic               smp_valid_o,
    input  logic               smp_ready_i,
    output logic [2:0]         smp_idx_o,
    output logic [63:0]        smp_data_o,
    output logic               smp_last_o,
    output logic               busy_o,
    output logic               overrun_o,
    output logic [15:0]        drop_cnt_o
);

    localparam logic [11:0] LoBase  = 12'hB03;
    localparam logic [11:0] HiBase  = 12'hB83;
    localparam logic [2:0]  LastCnt = 3'(NumCnt - 1);
    localparam bit          Split   = (XLEN == 32);
`ifdef HPM_SAMPLE_TIMESTAMP_EN
    localparam logic [2:0]  LastBeat = 3'(NumCnt);
`else
    localparam logic [2:0]  LastBeat = 3'(NumCnt - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        STREAM
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               half_q, half_d;
    logic [PeriodW-1:0] per_q;
    logic [63:0]        smp_buf_q [NumCnt];
    logic [15:0]        drop_q;
    logic               per_run, per_hit, trig, cap_go, drop;
    logic [11:0]        eng_addr;
    logic [63:0]        beat_data;
    logic [2:0]         beat_idx;

    assign per_run = sample_en_i && (sample_period_i != '0) && !debug_mode_i;
    // >= so a period shortened below the running count fires at once
    assign per_hit = per_run && (per_q >= sample_period_i - PeriodW'(1));
    assign trig    = per_hit || trigger_i;
    assign drop    = trig && (state_q != IDLE);
    assign cap_go  = (state_q == CAPTURE) && !csr_req_i && !debug_mode_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            per_q <= '0;
        end else if (!sample_en_i || per_hit) begin
            per_q <= '0;
        end else if (per_run) begin
            per_q <= per_q + PeriodW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        half_d  = half_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = CAPTURE;
                    idx_d   = '0;
                    half_d  = 1'b0;
                end
            end
            CAPTURE: begin
                if (cap_go) begin
                    if (Split && !half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (idx_q == LastCnt) begin
                            state_d = STREAM;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            STREAM: begin
                if (smp_ready_i) begin
                    if (idx_q == LastBeat) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                half_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumCnt); i++) begin
                smp_buf_q[i] <= '0;
            end
        end else if (cap_go) begin
            if (!Split) begin
                smp_buf_q[idx_q] <= 64'(pc_rdata_i);
            end else if (half_q) begin
                smp_buf_q[idx_q][63:32] <= pc_rdata_i[31:0];
            end else begin
                smp_buf_q[idx_q][31:0] <= pc_rdata_i[31:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

`ifdef HPM_SAMPLE_TIMESTAMP_EN
    logic [63:0] ts_q, ts_lat_q;
    logic        ts_beat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q     <= '0;
            ts_lat_q <= '0;
        end else begin
            ts_q <= ts_q + 64'd1;
            if ((state_q == IDLE) && trig) begin
                ts_lat_q <= ts_q;
            end
        end
    end

    assign ts_beat   = (idx_q == LastBeat);
    assign beat_data = ts_beat ? ts_lat_q
                               : smp_buf_q[ts_beat ? LastCnt : idx_q];
    assign beat_idx  = ts_beat ? 3'd7 : idx_q;
`else
    assign beat_data = smp_buf_q[idx_q];
    assign beat_idx  = idx_q;
`endif

    assign eng_addr = (state_q == CAPTURE)
                    ? ((half_q ? HiBase : LoBase) + 12'(idx_q))
                    : 12'h000;

    // CSR traffic always owns the port; the engine only ever reads
    assign pc_addr_o   = csr_req_i ? csr_addr_i : eng_addr;
    assign pc_we_o     = csr_req_i && csr_we_i;
    assign pc_wdata_o  = csr_req_i ? csr_wdata_i : '0;
    assign csr_rdata_o = csr_req_i ? pc_rdata_i : '0;

    assign smp_valid_o = (state_q == STREAM);
    assign smp_idx_o   = smp_valid_o ? beat_idx : 3'd0;
    assign smp_data_o  = smp_valid_o ? beat_data : 64'd0;
    assign smp_last_o  = smp_valid_o && (idx_q == LastBeat);
    assign busy_o      = (state_q != IDLE);
    assign overrun_o   = drop;
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_hpm_sample_ctrl.sv
// Bench for hpm_sample_ctrl: vector table, directed corner sequences and a
// randomized run checked every cycle against a work-queue model.
module tb_hpm_sample_ctrl;
    localparam int N = 6;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        debug_mode_i = 1'b0;
    logic        csr_req_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic        csr_we_i = 1'b0;
    logic [63:0] csr_wdata_i = '0;
    logic        sample_en_i = 1'b0;
    logic [31:0] sample_period_i = '0;
    logic        trigger_i = 1'b0;
    logic        smp_ready_i = 1'b0;

    logic [63:0] csr_rdata_o, pc_wdata_o, pc_rdata_i, smp_data_o;
    logic [11:0] pc_addr_o;
    logic        pc_we_o, smp_valid_o, smp_last_o, busy_o, overrun_o;
    logic [2:0]  smp_idx_o;
    logic [15:0] drop_cnt_o;

    logic [31:0] r32_csr, r32_wd, r32_rd;
    logic [11:0] r32_addr;
    logic        r32_we, r32_valid, r32_last, r32_busy, r32_over;
    logic [2:0]  r32_idx;
    logic [63:0] r32_data;
    logic [15:0] r32_drop;

    logic [63:0] mem [N] = '{default: 64'd0};
    logic [63:0] m32 [N] = '{default: 64'd0};

    int nvec = 0;
    int nerr = 0;

    always #5 clk_i = ~clk_i;

    hpm_sample_ctrl #(.XLEN(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug_mode_i),
        .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .pc_addr_o(pc_addr_o), .pc_we_o(pc_we_o), .pc_wdata_o(pc_wdata_o),
        .pc_rdata_i(pc_rdata_i), .sample_en_i(sample_en_i),
        .sample_period_i(sample_period_i), .trigger_i(trigger_i),
        .smp_valid_o(smp_valid_o), .smp_ready_i(smp_ready_i),
        .smp_idx_o(smp_idx_o), .smp_data_o(smp_data_o),
        .smp_last_o(smp_last_o), .busy_o(busy_o), .overrun_o(overrun_o),
        .drop_cnt_o(drop_cnt_o)
    );

    hpm_sample_ctrl #(.XLEN(32)) dut32 (
        .clk_i(clk_i), .rst_ni(rst_ni), .debug_mode_i(debug_mode_i),
        .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i),
        .csr_wdata_i(csr_wdata_i[31:0]), .csr_rdata_o(r32_csr),
        .pc_addr_o(r32_addr), .pc_we_o(r32_we), .pc_wdata_o(r32_wd),
        .pc_rdata_i(r32_rd), .sample_en_i(sample_en_i),
        .sample_period_i(sample_period_i), .trigger_i(trigger_i),
        .smp_valid_o(r32_valid), .smp_ready_i(smp_ready_i),
        .smp_idx_o(r32_idx), .smp_data_o(r32_data),
        .smp_last_o(r32_last), .busy_o(r32_busy), .overrun_o(r32_over),
        .drop_cnt_o(r32_drop)
    );

    // Perf-counter block models: static counters, written only via CSR.
    function automatic logic [63:0] rd64(input logic [11:0] a);
        if (a >= 12'hB03 && a < 12'hB03 + 12'(N)) return mem[a - 12'hB03];
        return 64'd0;
    endfunction

    function automatic logic [31:0] rd32(input logic [11:0] a);
        if (a >= 12'hB03 && a < 12'hB03 + 12'(N)) return m32[a - 12'hB03][31:0];
        if (a >= 12'hB83 && a < 12'hB83 + 12'(N)) return m32[a - 12'hB83][63:32];
        return 32'd0;
    endfunction

    assign pc_rdata_i = rd64(pc_addr_o);
    assign r32_rd     = rd32(r32_addr);

    always @(posedge clk_i) begin
        if (pc_we_o && pc_addr_o >= 12'hB03 && pc_addr_o < 12'hB03 + 12'(N))
            mem[pc_addr_o - 12'hB03] <= pc_wdata_o;
        if (r32_we && r32_addr >= 12'hB03 && r32_addr < 12'hB03 + 12'(N))
            m32[r32_addr - 12'hB03][31:0] <= r32_wd;
        if (r32_we && r32_addr >= 12'hB83 && r32_addr < 12'hB83 + 12'(N))
            m32[r32_addr - 12'hB83][63:32] <= r32_wd;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding reads plus a queue of expected beats.
    typedef struct {
        logic [2:0]  idx;
        logic [63:0] d;
        logic        last;
    } beat_t;

    beat_t       m_q [$];
    int          m_cap = 0;
    longint      m_per = 0;
    int          m_drop = 0;
    logic [63:0] snap [N];

    function automatic bit m_hit();
        return sample_en_i && sample_period_i != 0 && !debug_mode_i &&
               m_per >= longint'(sample_period_i) - 1;
    endfunction

    function automatic bit m_busy();
        return m_cap > 0 || m_q.size() > 0;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cap = 0;
            m_per = 0;
            m_drop = 0;
            m_q.delete();
        end else begin
            automatic bit hit = m_hit();
            automatic bit trig = hit || trigger_i;
            automatic bit busy = m_busy();
            if (!sample_en_i || hit) m_per = 0;
            else if (sample_period_i != 0 && !debug_mode_i) m_per++;
            if (trig && busy && m_drop < 65535) m_drop++;
            if (!busy) begin
                if (trig) m_cap = N;
            end else if (m_cap > 0) begin
                if (!csr_req_i && !debug_mode_i) begin
                    snap[N - m_cap] = mem[N - m_cap];
                    m_cap--;
                    if (m_cap == 0)
                        for (int k = 0; k < N; k++)
                            m_q.push_back('{3'(k), snap[k], k == N - 1});
                end
            end else if (smp_ready_i) begin
                void'(m_q.pop_front());
            end
        end
    end

    always @(negedge clk_i) begin
        automatic logic [11:0] ea;
        automatic bit sv = (m_cap == 0) && (m_q.size() > 0);
        ea = csr_req_i ? csr_addr_i
           : (m_cap > 0 ? 12'hB03 + 12'(N - m_cap) : 12'h000);
        chk("pc_addr", 64'(pc_addr_o), 64'(ea));
        chk("pc_we", 64'(pc_we_o), 64'(csr_req_i && csr_we_i));
        chk("csr_rdata", csr_rdata_o, csr_req_i ? rd64(csr_addr_i) : 64'd0);
        chk("busy", 64'(busy_o), 64'(m_busy()));
        chk("valid", 64'(smp_valid_o), 64'(sv));
        chk("overrun", 64'(overrun_o), 64'((m_hit() || trigger_i) && m_busy()));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
        if (sv && smp_valid_o) begin
            chk("beat_idx", 64'(smp_idx_o), 64'(m_q[0].idx));
            chk("beat_data", smp_data_o, m_q[0].d);
            chk("beat_last", 64'(smp_last_o), 64'(m_q[0].last));
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        csr_req_i = 0; csr_we_i = 0; trigger_i = 0; debug_mode_i = 0;
        sample_en_i = 0; smp_ready_i = 1;
    endtask

    task automatic do_reset();
        quiet();
        rst_ni = 0;
        repeat (2) cyc();
        rst_ni = 1;
    endtask

    task automatic pulse_trig();
        cyc();
        trigger_i = 1;
        cyc();
        trigger_i = 0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy_o || r32_busy) && t < 300) begin cyc(); t++; end
        chk({name, "_idle_timeout"}, 64'(t < 300), 64'd1);
    endtask

    // Count busy cycles of one sample; mode 1 stalls with CSR reads of
    // 0xB05, mode 2 stalls with debug mode, on counts s0..s0+3.
    task automatic run_sample(input int mode, input int s0, output int n);
        n = 0;
        pulse_trig();
        while (busy_o && n < 300) begin
            n++;
            csr_req_i = (mode == 1) && n >= s0 && n < s0 + 4;
            csr_addr_i = 12'hB05;
            debug_mode_i = (mode == 2) && n >= s0 && n < s0 + 4;
            @(negedge clk_i);
            if (csr_req_i) begin
                chk("stall_addr", 64'(pc_addr_o), 64'hB05);
                chk("stall_rdata", csr_rdata_o, mem[2]);
            end
            cyc();
        end
        csr_req_i = 0;
        debug_mode_i = 0;
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [11:0] a;
        logic [63:0] wd;
        logic [11:0] ea;
        logic [63:0] er;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int n, t, starts, overs;
        logic pb;
        logic [63:0] hd;

        for (int k = 0; k < N; k++) begin
            tbl[k] = '{1, 1, 12'hB03 + 12'(k), 64'(k + 1), 12'hB03 + 12'(k), 64'd0};
            tbl[k + N] = '{1, 0, 12'hB03 + 12'(k), 64'd0, 12'hB03 + 12'(k), 64'(k + 1)};
        end
        tbl[12] = '{1, 0, 12'hB00, 64'd0, 12'hB00, 64'd0};
        tbl[13] = '{0, 1, 12'hB05, 64'hDEAD, 12'h000, 64'd0};

        quiet();
        cyc();
        chk("rst_pc_addr", 64'(pc_addr_o), 64'd0);
        chk("rst_valid", 64'(smp_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_data", smp_data_o, 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        do_reset();

        foreach (tbl[i]) begin
            cyc();
            csr_req_i = tbl[i].req;
            csr_we_i = tbl[i].we;
            csr_addr_i = tbl[i].a;
            csr_wdata_i = tbl[i].wd;
            @(negedge clk_i);
            chk("tbl_addr", 64'(pc_addr_o), 64'(tbl[i].ea));
            chk("tbl_we", 64'(pc_we_o), 64'(tbl[i].req & tbl[i].we));
            chk("tbl_wdata", pc_wdata_o, tbl[i].req ? tbl[i].wd : 64'd0);
            chk("tbl_rdata", csr_rdata_o, tbl[i].er);
        end
        cyc();
        quiet();

        run_sample(0, 0, n);
        chk("busy_len_plain", 64'(n), 64'd12);

        run_sample(1, 3, n);
        chk("busy_len_csr_stall", 64'(n), 64'd16);

        run_sample(2, 3, n);
        chk("busy_len_debug", 64'(n), 64'd16);

        sample_en_i = 1;
        sample_period_i = 20;
        starts = 0;
        overs = 0;
        pb = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (busy_o && !pb) starts++;
            pb = busy_o;
        end
        chk("period20_starts", 64'(starts), 64'd5);
        chk("period20_drops", 64'(drop_cnt_o), 64'd0);
        sample_period_i = 5;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (overrun_o) overs++;
        end
        chk("period5_overrun", 64'(overs > 0), 64'd1);
        chk("period5_drops", 64'(drop_cnt_o > 0), 64'd1);
        sample_en_i = 0;
        wait_idle("period");

        do_reset();
        pulse_trig();
        t = 0;
        while (!(smp_valid_o && smp_idx_o == 3'd2) && t < 100) begin cyc(); t++; end
        chk("reach_beat2", 64'(t < 100), 64'd1);
        smp_ready_i = 0;
        hd = smp_data_o;
        for (int i = 0; i < 10; i++) begin
            trigger_i = (i == 4);
            cyc();
            chk("hold_idx", 64'(smp_idx_o), 64'd2);
            chk("hold_data", smp_data_o, hd);
        end
        chk("hold_data_val", hd, mem[2]);
        chk("hold_drop", 64'(drop_cnt_o), 64'd1);
        smp_ready_i = 1;
        wait_idle("hold");

        do_reset();
        cyc();
        csr_req_i = 1; csr_we_i = 1;
        csr_addr_i = 12'hB03; csr_wdata_i = 64'hFFFF_FFFF;
        cyc();
        csr_addr_i = 12'hB83; csr_wdata_i = 64'h1;
        cyc();
        csr_req_i = 0; csr_we_i = 0;
        trigger_i = 1;
        cyc();
        trigger_i = 0;
        for (int k = 1; k <= 12; k++) begin
            chk("x32_addr", 64'(r32_addr),
                64'((k % 2 == 1) ? 12'hB03 + 12'((k - 1) / 2)
                                 : 12'hB83 + 12'((k - 2) / 2)));
            cyc();
        end
        chk("x32_valid", 64'(r32_valid), 64'd1);
        chk("x32_idx", 64'(r32_idx), 64'd0);
        chk("x32_data", r32_data, 64'h1_FFFF_FFFF);
        wait_idle("x32");

        pulse_trig();
        t = 0;
        while (!smp_valid_o && t < 50) begin cyc(); t++; end
        chk("reach_stream", 64'(t < 50), 64'd1);
        #2 rst_ni = 0;
        #1;
        chk("rst_mid_valid", 64'(smp_valid_o), 64'd0);
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        cyc();
        rst_ni = 1;
        repeat (3) cyc();
        chk("post_rst_valid", 64'(smp_valid_o), 64'd0);

        for (int i = 0; i < 400; i++) begin
            cyc();
            csr_req_i = ($urandom_range(0, 4) == 0);
            csr_we_i = ($urandom_range(0, 7) == 0);
            csr_addr_i = 12'hB00 + 12'($urandom_range(0, 10));
            csr_wdata_i = {$urandom, $urandom};
            trigger_i = ($urandom_range(0, 19) == 0);
            smp_ready_i = ($urandom_range(0, 3) != 0);
            debug_mode_i = ($urandom_range(0, 9) == 0);
            if (i % 100 == 0) begin
                sample_en_i = ($urandom_range(0, 3) != 0);
                sample_period_i = 32'($urandom_range(0, 40));
            end
        end
        quiet();
        wait_idle("random");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hpm_sample_ctrl.md
Name: hpm_sample_ctrl

Overview:
- Sits between the CSR file and the performance-counter block's SRAM-like port (addr/we/wdata/rdata), and arbitrates that port.
- Adds a sampling engine. On a periodic timer or an external trigger, the engine snapshots all six mhpmcounters (3..8) into a buffer, then streams them out on a valid/ready interface to a trace/debug sink.
- CSR accesses always have priority. The engine only uses the port in idle cycles.

Parameters:
- XLEN, 64, CSR data width; legal values 32 or 64.
- NumCnt, 6, number of generic counters sampled; counter k maps to CSR address 0xB03+k, and its high half to 0xB83+k.
- PeriodW, 32, width of the sample period register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- debug_mode_i  in  1  core in debug mode
- csr_req_i  in  1  CSR access request (single cycle)
- csr_addr_i  in  12  CSR address
- csr_we_i  in  1  CSR write
- csr_wdata_i  in  XLEN  CSR write data
- csr_rdata_o  out  XLEN  CSR read data (combinational passthrough)
- pc_addr_o  out  12  perf-counter port address
- pc_we_o  out  1  perf-counter port write enable
- pc_wdata_o  out  XLEN  perf-counter port write data
- pc_rdata_i  in  XLEN  perf-counter port read data (combinational from pc_addr_o)
- sample_en_i  in  1  enable periodic sampling
- sample_period_i  in  PeriodW  cycles between samples; 0 disables the periodic trigger
- trigger_i  in  1  one-shot sample request (pulse)
- smp_valid_o  out  1  sample beat valid
- smp_ready_i  in  1  sink ready
- smp_idx_o  out  3  counter index, 0..NumCnt-1
- smp_data_o  out  64  counter value
- smp_last_o  out  1  final beat of a sample
- busy_o  out  1  engine not IDLE
- overrun_o  out  1  single-cycle pulse when a trigger is dropped
- drop_cnt_o  out  16  saturating count of dropped triggers

Behaviour:
- Reset: FSM=IDLE; period counter=0; buffer=0; all outputs 0; pc_addr_o=0.
- Arbitration (combinational):
  - csr_req_i=1 → pc_addr_o=csr_addr_i, pc_we_o=csr_we_i, pc_wdata_o=csr_wdata_i; engine stalls that cycle.
  - Otherwise pc_addr_o = engine address, pc_we_o=0.
  - csr_rdata_o=pc_rdata_i whenever csr_req_i=1, else 0.
  - The engine never writes.
- Period counter:
  - Counts up each cycle while sample_en_i=1, sample_period_i!=0 and !debug_mode_i.
  - At value sample_period_i-1 it raises a periodic trigger and wraps to 0.
  - Cleared whenever sample_en_i=0.
  - sample_period_i=1 → trigger every cycle.
- Trigger = periodic | trigger_i; simultaneous sources count as one.
  - In IDLE: trigger → CAPTURE, index=0, half=0.
  - Not in IDLE: trigger is dropped; overrun_o pulses, drop_cnt_o increments and saturates at 0xFFFF.
- CAPTURE:
  - Each cycle with csr_req_i=0 and !debug_mode_i, read pc_rdata_i into buf[index].
  - XLEN=64: address 0xB03+index, one read per counter.
  - XLEN=32: low half (0xB03+index), then high half (0xB83+index), two reads per counter.
  - After the last read (index NumCnt-1, final half) → STREAM, index=0.
  - Capture of 6 counters takes 6 (XLEN=64) or 12 (XLEN=32) non-stalled cycles. The snapshot is not atomic across counters; this is accepted.
  - A CSR write to a counter during CAPTURE takes effect in the buffer only if that counter has not yet been read.
- STREAM:
  - smp_valid_o=1; smp_idx_o=index; smp_data_o=buf[index] (zero-extended for XLEN=32); smp_last_o=1 on the final beat.
  - Data, idx and last stay stable while valid && !ready.
  - On valid&&ready: index++. After the last beat → IDLE, in the same cycle.
  - STREAM does not use the port and is unaffected by csr_req_i or debug_mode_i.
- debug_mode_i freezes the period counter and CAPTURE progress. STREAM continues.
- busy_o=1 in CAPTURE and STREAM.
- Reset mid-operation abandons the sample immediately; no partial beats after reset.

Optional Feature:
- HPM_SAMPLE_TIMESTAMP_EN defined:
  - Adds a free-running 64-bit cycle counter (reset 0).
  - Its value is latched on the trigger accepted from IDLE.
  - STREAM emits one extra final beat: smp_idx_o=7, data=latched timestamp, smp_last_o=1 on this beat only.
- Undefined: no timestamp logic; NumCnt beats per sample.

Test Plan:
- XLEN=64; counters preset to 1..6 via CSR writes; trigger_i pulse, smp_ready_i=1 → beats idx0..5 with data 1..6, last on idx5; busy_o high for 6+6 cycles.
- sample_en_i=1, sample_period_i=20, ready=1 → a sample starts every 20 cycles, drop_cnt_o=0. Then sample_period_i=5 → overrun_o pulses and drop_cnt_o increments.
- csr_req_i held high for 4 cycles mid-CAPTURE → pc_addr_o follows csr_addr_i; capture completes 4 cycles later; CSR read of 0xB05 returns the live value.
- smp_ready_i held low 10 cycles on beat idx2 → smp_data_o/smp_idx_o stable; trigger_i during stall → dropped, drop_cnt_o=1.
- XLEN=32; counter 3 = 0x0000_0001_FFFF_FFFF → 12 capture reads alternating 0xB03/0xB83..; beat idx0 data 0x1_FFFF_FFFF.
- debug_mode_i=1 during CAPTURE → period counter and capture frozen; rst_ni asserted in STREAM → smp_valid_o=0, busy_o=0 immediately.
